// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    // Controller states: waiting for operands, iterating, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Widest operand the sign helper handles; callers widen into it and
    // truncate the result back to their own width.
    localparam int MAX_W = 64;

    // Two's-complement negate when neg is set, pass-through otherwise.
    // Used both to take magnitudes on accept and to restore signs at the end.
    function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] v,
                                                     input logic             neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step (purely combinational).
module div_step #(
    parameter int M = 32
) (
    input  logic [M-1:0] rem,
    input  logic         dividend_msb,
    input  logic [M-1:0] divisor,
    output logic [M-1:0] next_rem,
    output logic         q_bit
);

    logic [M:0] partial;

    // Shift the next dividend bit into the remainder and subtract if it fits.
    // The comparison is M+1 bits wide so a remainder with its MSB set still
    // compares correctly against large divisors.
    always_comb begin
        partial  = {rem, dividend_msb};
        next_rem = partial[M-1:0];
        q_bit    = 1'b0;
        if (partial >= {1'b0, divisor}) begin
            next_rem = M'(partial - {1'b0, divisor});
            q_bit    = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider with valid/ready on both sides,
// optional two's-complement mode and deterministic divide-by-zero results.
module seq_divider
    import div_pkg::*;
#(
    parameter int M         = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    input  logic         is_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         error,
    output logic         busy
);

    localparam int CNT_W = $clog2(M);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [M-1:0]     rem_q, rem_d;
    logic [M-1:0]     dq_q, dq_d;        // dividend bits shift out, quotient bits shift in
    logic [M-1:0]     dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [M-1:0]     quotient_q, quotient_d;
    logic [M-1:0]     remainder_q, remainder_d;
    logic             error_q, error_d;

    logic             mode_signed;
    logic             a_neg, b_neg;
    logic [M-1:0]     a_mag, b_mag;
    logic [M-1:0]     step_rem;
    logic             step_q_bit;
    logic [M-1:0]     q_shift;

    div_step #(.M(M)) u_step (
        .rem          (rem_q),
        .dividend_msb (dq_q[M-1]),
        .divisor      (dvs_q),
        .next_rem     (step_rem),
        .q_bit        (step_q_bit)
    );

    // Operand magnitudes and sign flags, consumed only on the accept cycle.
    always_comb begin
        mode_signed = is_signed && SIGNED_EN;
        a_neg       = mode_signed && A[M-1];
        b_neg       = mode_signed && B[M-1];
        a_mag       = M'(cond_negate(MAX_W'(A), a_neg));
        b_mag       = M'(cond_negate(MAX_W'(B), b_neg));
    end

    // Next-state and datapath update; registers hold unless a state acts.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dq_d        = dq_q;
        dvs_d       = dvs_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        error_d     = error_q;
        q_shift     = {dq_q[M-2:0], step_q_bit};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (B == '0) begin
                        // Divide by zero skips the iteration entirely.
                        error_d     = 1'b1;
                        quotient_d  = '1;
                        remainder_d = A;
                        state_d     = DONE;
                    end else begin
                        error_d   = 1'b0;
                        rem_d     = '0;
                        dq_d      = a_mag;
                        dvs_d     = b_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = CNT_W'(M - 1);
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dq_d  = q_shift;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    // Last step: restore signs while publishing the result.
                    // MIN_INT / -1 wraps naturally to MIN_INT here.
                    quotient_d  = M'(cond_negate(MAX_W'(q_shift), neg_quo_q));
                    remainder_d = M'(cond_negate(MAX_W'(step_rem), neg_rem_q));
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dq_q        <= dq_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign error     = error_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: one 32-bit signed-capable divider, plus a pair of
// 8-bit dividers (signed-capable and unsigned-only) driven in lockstep.
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        in_valid32, sgn32, out_ready32;
    logic [31:0] a32, b32;
    logic        in_ready32, out_valid32, error32, busy32;
    logic [31:0] q32, r32;

    // 8-bit pair sharing inputs
    logic        in_valid8, sgn8, out_ready8;
    logic [7:0]  a8, b8;
    logic        in_ready8, out_valid8, error8, busy8;
    logic [7:0]  q8, r8;
    logic        in_ready8u, out_valid8u, error8u, busy8u;
    logic [7:0]  q8u, r8u;

    seq_divider #(.M(32), .SIGNED_EN(1'b1)) u_div32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .A(a32), .B(b32), .is_signed(sgn32), .out_valid(out_valid32),
        .out_ready(out_ready32), .quotient(q32), .remainder(r32),
        .error(error32), .busy(busy32)
    );

    seq_divider #(.M(8), .SIGNED_EN(1'b1)) u_div8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .is_signed(sgn8), .out_valid(out_valid8),
        .out_ready(out_ready8), .quotient(q8), .remainder(r8),
        .error(error8), .busy(busy8)
    );

    seq_divider #(.M(8), .SIGNED_EN(1'b0)) u_div8u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8u),
        .A(a8), .B(b8), .is_signed(sgn8), .out_valid(out_valid8u),
        .out_ready(out_ready8), .quotient(q8u), .remainder(r8u),
        .error(error8u), .busy(busy8u)
    );

    // Selected-group views so one transaction task serves both widths.
    logic        cur8;
    logic        cur_in_ready, cur_out_valid, cur_err, cur_busy;
    logic [31:0] cur_q, cur_r;
    assign cur_in_ready  = cur8 ? in_ready8  : in_ready32;
    assign cur_out_valid = cur8 ? out_valid8 : out_valid32;
    assign cur_err       = cur8 ? error8     : error32;
    assign cur_busy      = cur8 ? busy8      : busy32;
    assign cur_q         = cur8 ? {24'd0, q8} : q32;
    assign cur_r         = cur8 ? {24'd0, r8} : r32;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s.%s: observed %h expected %h", tag, what, obs, exp);
        end
    endtask

    // Reference: plain integer division on w-bit values.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic sgn, output logic [31:0] q,
                                  output logic [31:0] r, output logic e);
        longint sa, sb, lq, lr, span;
        span = longint'(1) << w;
        sa   = longint'(a);
        sb   = longint'(b);
        if (b == 32'd0) begin
            q = 32'(span - 1);
            r = a;
            e = 1'b1;
            return;
        end
        if (sgn) begin
            if (sa >= span / 2) sa = sa - span;
            if (sb >= span / 2) sb = sb - span;
        end
        lq = sa / sb;
        lr = sa % sb;
        q  = 32'(lq & (span - 1));
        r  = 32'(lr & (span - 1));
        e  = 1'b0;
    endfunction

    task automatic drive_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        if (cur8) begin
            in_valid8 = v; a8 = a[7:0]; b8 = b[7:0]; sgn8 = s;
        end else begin
            in_valid32 = v; a32 = a; b32 = b; sgn32 = s;
        end
    endtask

    task automatic set_out_ready(input logic v);
        if (cur8) out_ready8 = v;
        else      out_ready32 = v;
    endtask

    // One full transaction: accept, latency, result, optional backpressure
    // window (with an optional ignored request), handshake, return to idle.
    task automatic run_op(input logic use8, input logic [31:0] a_in, input logic [31:0] b_in,
                          input logic sgn, input int hold, input logic poke, input string tag);
        logic [31:0] a, b, eq, er, equ, eru;
        logic        ee, eeu;
        int          w, lat, waited, exp_lat;
        cur8 = use8;
        w    = use8 ? 8 : 32;
        a    = use8 ? (a_in & 32'hFF) : a_in;
        b    = use8 ? (b_in & 32'hFF) : b_in;
        model(w, a, b, sgn, eq, er, ee);
        model(8, a, b, 1'b0, equ, eru, eeu);

        @(negedge clk);
        set_out_ready(hold == 0);
        drive_in(1'b1, a, b, sgn);
        waited = 0;
        while (!cur_in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check(tag, "in_ready_at_accept", {31'd0, cur_in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive_in(1'b0, 32'd0, 32'd0, 1'b0);
        lat = 1;
        while (!cur_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        exp_lat = (b == 32'd0) ? 1 : w + 1;
        check(tag, "latency", 32'(lat), 32'(exp_lat));
        check(tag, "quotient", cur_q, eq);
        check(tag, "remainder", cur_r, er);
        check(tag, "error", {31'd0, cur_err}, {31'd0, ee});
        if (use8) begin
            check(tag, "u_valid", {31'd0, out_valid8u}, 32'd1);
            check(tag, "u_quotient", {24'd0, q8u}, equ);
            check(tag, "u_remainder", {24'd0, r8u}, eru);
            check(tag, "u_error", {31'd0, error8u}, {31'd0, eeu});
        end

        for (int i = 0; i < hold; i++) begin
            if (poke) drive_in(1'b1, a + 32'd1, b, sgn);
            @(negedge clk);
            check(tag, "bp_valid", {31'd0, cur_out_valid}, 32'd1);
            check(tag, "bp_in_ready", {31'd0, cur_in_ready}, 32'd0);
            check(tag, "bp_busy", {31'd0, cur_busy}, 32'd1);
            check(tag, "bp_quotient", cur_q, eq);
            check(tag, "bp_remainder", cur_r, er);
        end
        drive_in(1'b0, 32'd0, 32'd0, 1'b0);
        set_out_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        check(tag, "idle_in_ready", {31'd0, cur_in_ready}, 32'd1);
        check(tag, "idle_valid", {31'd0, cur_out_valid}, 32'd0);
        check(tag, "idle_quotient_held", cur_q, eq);
        $display("txn %s: w=%0d A=%h B=%h s=%0d -> q=%h r=%h err=%0d lat=%0d",
                 tag, w, a, b, sgn, cur_q, cur_r, cur_err, lat);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask, v;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        v    = $urandom & mask;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = mask;
            3: v = 32'd1 << (w - 1);
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        cur8 = 1'b0;
        rst_n = 1'b0;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; sgn32 = 1'b0; out_ready32 = 1'b0;
        in_valid8  = 1'b0; a8  = '0; b8  = '0; sgn8  = 1'b0; out_ready8  = 1'b0;
        #1;
        check("reset", "in_ready", {31'd0, in_ready32}, 32'd1);
        check("reset", "out_valid", {31'd0, out_valid32}, 32'd0);
        check("reset", "busy", {31'd0, busy32}, 32'd0);
        check("reset", "quotient", q32, 32'd0);
        check("reset", "remainder", r32, 32'd0);
        check("reset", "error", {31'd0, error32}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 1'b0, 0, 1'b0, "u100_7");
        run_op(1'b0, 32'h1234, 32'd0, 1'b0, 0, 1'b0, "div0_u");
        run_op(1'b0, 32'h1234, 32'd0, 1'b1, 0, 1'b0, "div0_s");
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0, "s_m7_2");
        run_op(1'b0, 32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0, "s_7_m2");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, "s_min_m1");
        run_op(1'b0, 32'd50, 32'd5, 1'b0, 10, 1'b1, "bp50_5");
        run_op(1'b1, 32'h34, 32'd0, 1'b1, 0, 1'b0, "div0_8");
        run_op(1'b1, 32'h80, 32'hFF, 1'b1, 0, 1'b0, "s8_min_m1");

        // Abort mid-iteration with an asynchronous reset.
        cur8 = 1'b0;
        @(negedge clk);
        set_out_ready(1'b1);
        drive_in(1'b1, 32'd1000, 32'd3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive_in(1'b0, 32'd0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid", "in_ready", {31'd0, in_ready32}, 32'd1);
        check("rst_mid", "out_valid", {31'd0, out_valid32}, 32'd0);
        check("rst_mid", "busy", {31'd0, busy32}, 32'd0);
        check("rst_mid", "quotient", q32, 32'd0);
        check("rst_mid", "remainder", r32, 32'd0);
        check("rst_mid", "error", {31'd0, error32}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 32'd9, 32'd3, 1'b0, 0, 1'b0, "after_rst");

        for (int i = 0; i < 30; i++) begin
            ra = pick(32);
            rb = ($urandom_range(0, 5) == 0) ? ra : pick(32);
            rs = 1'($urandom_range(0, 1));
            run_op(1'b0, ra, rb, rs, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rnd32");
        end
        for (int i = 0; i < 60; i++) begin
            ra = pick(8);
            rb = ($urandom_range(0, 5) == 0) ? ra : pick(8);
            rs = 1'($urandom_range(0, 1));
            run_op(1'b1, ra, rb, rs, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rnd8");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
